// File: rtl/axis_packetizer_if.sv
// AXI4-Stream link bundle: master drives data/valid/last, slave returns ready.
// Purely structural; no latency and no state.
interface axis_packetizer_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_packetizer.sv
// Frames an unframed AXIS stream into cfg_data+1 word packets and counts them; 1-cycle registered
// output, s_axis ready drops whenever the output register is full and stalled.
module axis_packetizer #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int CNTR_WIDTH       = 16
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  enable,
  input  logic [CNTR_WIDTH-1:0] cfg_data,
  output logic [31:0]           sts_data,
  axis_packetizer_if.slave      s_axis,
  axis_packetizer_if.master     m_axis
);
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e                      state_q, state_d;
  logic [CNTR_WIDTH-1:0]       cnt_q, cnt_d;
  logic [CNTR_WIDTH-1:0]       len_q, len_d;
  logic [31:0]                 sts_q, sts_d;
  logic [AXIS_TDATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                        tvalid_q, tvalid_d;
  logic                        tlast_q, tlast_d;

  logic s_rdy;
  logic accept;
  logic at_last;

  // Counter never exceeds the latched length, so an exact compare closes the packet.
  assign at_last = (cnt_q == len_q);
  assign s_rdy   = (state_q == RUN) && (enable || (cnt_q != '0)) && (!tvalid_q || m_axis.tready);
  assign accept  = s_axis.tvalid && s_rdy;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (enable) state_d = RUN;
      RUN: begin
        if (!enable && ((cnt_q == '0) || (accept && at_last))) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    len_d    = len_q;
    sts_d    = sts_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    if ((state_q == IDLE) && enable) begin
      len_d = cfg_data;
      cnt_d = '0;
    end
    if (accept) begin
      tdata_d  = s_axis.tdata;
      tvalid_d = 1'b1;
      tlast_d  = at_last;
      if (at_last) begin
        cnt_d = '0;
        sts_d = sts_q + 32'd1;
        len_d = cfg_data;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (m_axis.tready) begin
      tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      cnt_q    <= '0;
      len_q    <= '0;
      sts_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      sts_q    <= sts_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
    end
  end

  assign s_axis.tready = s_rdy;
  assign m_axis.tdata  = tdata_q;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tlast  = tlast_q;
  assign sts_data      = sts_q;
endmodule

// File: tb/tb_axis_packetizer.sv
// Randomized bench for axis_packetizer against a queue-based packet model.
module tb_axis_packetizer;
  localparam int DW = 32;
  localparam int CW = 16;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          enable = 1'b0;
  logic [CW-1:0] cfg_data = '0;
  logic [31:0]   sts_data;

  axis_packetizer_if #(.DATA_W(DW)) s_if ();
  axis_packetizer_if #(.DATA_W(DW)) m_if ();

  axis_packetizer #(.AXIS_TDATA_WIDTH(DW), .CNTR_WIDTH(CW)) dut (
    .aclk     (aclk),
    .areset   (areset),
    .enable   (enable),
    .cfg_data (cfg_data),
    .sts_data (sts_data),
    .s_axis   (s_if),
    .m_axis   (m_if)
  );

  initial forever #5 aclk = ~aclk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } owrd_t;

  // Reference: words accepted but not yet delivered, with their expected tlast.
  owrd_t       q[$];
  int          pos = 0;
  int          pkt_len = 1;
  logic [31:0] exp_sts = '0;
  bit          m_idle = 1'b1;
  int          acc_cnt = 0;
  int          bp_mode = 0;
  int          bp_cnt = 0;

  initial forever begin
    owrd_t w;
    bit    exp_rdy;
    @(negedge aclk);
    #4;
    if (areset) begin
      chk("rst_m_tvalid", m_if.tvalid, 1'b0);
      chk("rst_s_tready", s_if.tready, 1'b0);
      chk("rst_sts", sts_data, 32'd0);
      q.delete();
      pos     = 0;
      exp_sts = '0;
      m_idle  = 1'b1;
    end else begin
      chk("m_tvalid", m_if.tvalid, q.size() != 0);
      exp_rdy = !m_idle && (enable || pos != 0) && (q.size() == 0 || m_if.tready);
      chk("s_tready", s_if.tready, exp_rdy);
      chk("sts", sts_data, exp_sts);
      if (m_if.tvalid && m_if.tready && q.size() != 0) begin
        w = q.pop_front();
        chk("out_data", m_if.tdata, w.d);
        chk("out_last", m_if.tlast, w.l);
      end
      if (m_idle) begin
        if (enable) begin
          m_idle  = 1'b0;
          pos     = 0;
          pkt_len = int'(cfg_data) + 1;
        end
      end else if (s_if.tvalid && s_if.tready) begin
        acc_cnt++;
        pos++;
        w.d = s_if.tdata;
        w.l = (pos == pkt_len);
        q.push_back(w);
        if (w.l) begin
          pos     = 0;
          exp_sts = exp_sts + 32'd1;
          pkt_len = int'(cfg_data) + 1;
          if (!enable) m_idle = 1'b1;
        end
      end else if (!enable && pos == 0) begin
        m_idle = 1'b1;
      end
    end
  end

  initial begin
    m_if.tready = 1'b1;
    forever begin
      @(negedge aclk);
      case (bp_mode)
        1: begin
          m_if.tready = (bp_cnt % 4 == 0) || (bp_cnt % 4 == 3);
          bp_cnt++;
        end
        2:       m_if.tready = 1'($urandom_range(0, 1));
        default: m_if.tready = 1'b1;
      endcase
    end
  end

  task automatic send(input logic [DW-1:0] d);
    bit ok = 1'b0;
    s_if.tdata  = d;
    s_if.tvalid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      #4;
      ok = s_if.tready;
      @(negedge aclk);
    end
    s_if.tvalid = 1'b0;
    if (!ok) chk("send_timeout", ok, 1'b1);
  endtask

  task automatic gap(input int n);
    s_if.tvalid = 1'b0;
    repeat (n) @(negedge aclk);
  endtask

  task automatic do_reset();
    areset      = 1'b1;
    enable      = 1'b0;
    s_if.tvalid = 1'b0;
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tlast  = 1'b0;
    do_reset();

    // Basic framing, both sides always ready
    cfg_data = 16'd3;
    enable   = 1'b1;
    for (int k = 0; k < 12; k++) send(DW'(k));
    gap(4);
    chk("t1_sts", sts_data, 32'd3);

    // Output backpressure with ready pattern 1,0,0,1
    do_reset();
    cfg_data = 16'd1;
    enable   = 1'b1;
    bp_cnt   = 0;
    bp_mode  = 1;
    for (int k = 0; k < 12; k++) send($urandom);
    gap(8);
    bp_mode = 0;
    gap(2);
    chk("t2_sts", sts_data, 32'd6);

    // Enable dropped after the second word
    do_reset();
    cfg_data = 16'd4;
    enable   = 1'b1;
    send(32'hA000_0001);
    send(32'hA000_0002);
    enable = 1'b0;
    send(32'hA000_0003);
    send(32'hA000_0004);
    send(32'hA000_0005);
    acc0        = acc_cnt;
    s_if.tdata  = 32'hDEAD_BEEF;
    s_if.tvalid = 1'b1;
    repeat (6) begin
      #4;
      chk("t3_idle_rdy", s_if.tready, 1'b0);
      @(negedge aclk);
    end
    s_if.tvalid = 1'b0;
    chk("t3_no_extra", acc_cnt - acc0, 0);
    chk("t3_sts", sts_data, 32'd1);

    // Length change inside the first packet
    do_reset();
    cfg_data = 16'd2;
    enable   = 1'b1;
    send(32'h0000_0100);
    cfg_data = 16'd0;
    for (int k = 1; k < 7; k++) send(32'h0000_0100 + DW'(k));
    gap(3);
    chk("t4_sts", sts_data, 32'd5);

    // Single-word packets with random gaps and random output ready
    do_reset();
    cfg_data = 16'd0;
    enable   = 1'b1;
    bp_mode  = 2;
    for (int k = 0; k < 20; k++) begin
      gap($urandom_range(0, 2));
      send($urandom);
    end
    gap(6);
    bp_mode = 0;
    gap(4);
    chk("t5_sts", sts_data, 32'd20);

    // Asynchronous reset between edges in the middle of a packet
    do_reset();
    cfg_data = 16'd3;
    enable   = 1'b1;
    send(32'h1111_0001);
    send(32'h1111_0002);
    chk("t6_pre_vld", m_if.tvalid, 1'b1);
    #1 areset = 1'b1;
    enable = 1'b0;
    #1;
    chk("t6_rst_vld", m_if.tvalid, 1'b0);
    chk("t6_rst_last", m_if.tlast, 1'b0);
    chk("t6_rst_data", m_if.tdata, 32'd0);
    chk("t6_rst_rdy", s_if.tready, 1'b0);
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    enable = 1'b1;
    for (int k = 0; k < 4; k++) send(32'h2222_0000 + DW'(k));
    gap(3);
    chk("t6_sts", sts_data, 32'd1);
    chk("t6_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
